// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier with sign/magnitude handling.
// Unsigned or two's-complement operands. Latency is fixed at WIDTH+2 cycles
// from the clock edge that accepts start.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   start            - begin a multiplication (accepted in IDLE or DONE)
//   signed_mode      - 1: two's-complement operands/product, 0: unsigned
//   eX, Y            - multiplicand, multiplier (sampled with start)
//   A, Q             - product high/low halves (registered)
//   busy             - multiplication in progress (RUN or FIX)
//   done             - one-cycle pulse when {A,Q} holds a valid product
module shift_add_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] eX,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W  = $clog2(WIDTH) + 1;
    localparam int unsigned PROD_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               neg_q, neg_d;

    logic               accept_c;
    logic               last_run_c;
    logic [WIDTH-1:0]   mag_x_c;
    logic [WIDTH-1:0]   mag_y_c;
    logic [WIDTH-1:0]   addend_c;
    logic [WIDTH:0]     sum_c;
    logic [PROD_W-1:0]  neg_prod_c;

    // start only takes effect between operations
    assign accept_c   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_run_c = (count_q == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            count_q <= '0;
            neg_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            q_q     <= q_d;
            count_q <= count_d;
            neg_q   <= neg_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept_c) state_d = ST_RUN;
            ST_RUN:  if (last_run_c) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = accept_c ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned
    always_comb begin
        mag_x_c = eX;
        mag_y_c = Y;
        if (signed_mode && eX[WIDTH-1]) mag_x_c = (~eX) + WIDTH'(1);
        if (signed_mode && Y[WIDTH-1])  mag_y_c = (~Y) + WIDTH'(1);
    end

    // One add step and the final two's-complement correction
    always_comb begin
        addend_c   = q_q[0] ? b_q : '0;
        sum_c      = {1'b0, a_q} + {1'b0, addend_c};
        neg_prod_c = (~{a_q, q_q}) + PROD_W'(1);
    end

    // Datapath next values
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        q_d     = q_q;
        count_d = count_q;
        neg_d   = neg_q;
        if (accept_c) begin
            a_d     = '0;
            b_d     = mag_x_c;
            q_d     = mag_y_c;
            count_d = '0;
            neg_d   = signed_mode & (eX[WIDTH-1] ^ Y[WIDTH-1]);
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    // carry drops into A's MSB, S[0] shifts into Q
                    a_d     = sum_c[WIDTH:1];
                    q_d     = {sum_c[0], q_q[WIDTH-1:1]};
                    count_d = count_q + CNT_W'(1);
                end
                ST_FIX: begin
                    if (neg_q) {a_d, q_d} = neg_prod_c;
                end
                default: ;
            endcase
        end
    end

    // Status outputs decoded from registered state
    always_comb begin
        busy = (state_q == ST_RUN) || (state_q == ST_FIX);
        done = (state_q == ST_DONE);
    end

    assign A = a_q;
    assign Q = q_q;

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to begin a multiplication; sampled on rising clk.
REQ-005 signed_mode  input  1  1 = operands and product are two's complement, 0 = unsigned; sampled with start.
REQ-006 eX  input  WIDTH  multiplicand; sampled with start.
REQ-007 Y  input  WIDTH  multiplier; sampled with start.
REQ-008 A  output  WIDTH  product high half and partial-product accumulator (registered).
REQ-009 Q  output  WIDTH  product low half and multiplier shift register (registered).
REQ-010 busy  output  1  high while a multiplication is in progress (RUN or FIX).
REQ-011 done  output  1  one-cycle pulse when {A,Q} holds a valid product.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, FIX, DONE; busy = (RUN|FIX), done = DONE; both outputs are decoded from registered state only.
REQ-013 start SHALL be accepted only in IDLE or DONE; start in RUN or FIX SHALL be ignored, with no effect on state, registers or the product.
REQ-014 On acceptance the block SHALL load B <= |eX|, Q <= |Y|, A <= 0, neg <= eX[MSB]^Y[MSB], count <= 0, and go to RUN; with signed_mode=0 the absolute value is the raw operand and neg <= 0.
REQ-015 Magnitudes SHALL be formed as WIDTH-bit unsigned values, so the most negative operand (e.g. -128 at WIDTH=8) maps to 2^(WIDTH-1) without overflow.
REQ-016 Each RUN cycle SHALL form {c,S} = A + (Q[0] ? B : 0) at WIDTH+1 bits, then load {A,Q} <= {c,S,Q[WIDTH-1:1]}, and increment count.
REQ-017 RUN SHALL last exactly WIDTH cycles, then go to FIX.
REQ-018 FIX SHALL last one cycle: if neg=1, {A,Q} <= two's-complement negation of {A,Q} at 2*WIDTH bits; otherwise {A,Q} is unchanged. FIX then goes to DONE.
REQ-019 Latency SHALL be constant: done is high in the (WIDTH+2)th cycle after the accepting edge, independent of mode and operand values.
REQ-020 DONE SHALL last one cycle, then go to IDLE unless start is accepted in that cycle, in which case the next state is RUN.
REQ-021 {A,Q} SHALL hold the final product from DONE until the next accepted start; B and neg are internal and not visible at the outputs.
REQ-022 Product width SHALL be 2*WIDTH bits with no overflow for any operand pair in either mode; a zero product with neg=1 SHALL yield 0.
REQ-023 The count register SHALL be $clog2(WIDTH)+1 bits wide.

Reset
REQ-024 When rst_n=0, the block SHALL asynchronously set state=IDLE and A, B, Q, count, neg to 0, giving busy=0 and done=0.
REQ-025 Reset asserted mid-operation SHALL abort it immediately; no done pulse SHALL follow, and the first start after rst_n deasserts SHALL begin a fresh operation.

Verification (WIDTH=8)
REQ-026 Unsigned: start with eX=13, Y=11 -> done in 10th cycle after acceptance, {A,Q}=16'h008F, busy high for 9 cycles.
REQ-027 Unsigned: eX=255, Y=255 -> {A,Q}=16'hFE01 (exercises the carry in REQ-016).
REQ-028 Signed: eX=-3 (8'hFD), Y=5 -> 16'hFFF1; eX=-128, Y=-128 -> 16'h4000; eX=-128, Y=1 -> 16'hFF80; eX=-5, Y=0 -> 16'h0000.
REQ-029 Handshake: start pulsed during RUN with different operands -> ignored, first product unchanged; start held high in DONE -> back-to-back operation, second done exactly 10 cycles after the first.
REQ-030 Reset: rst_n pulsed low during cycle 4 of RUN -> A=Q=0, busy=0 immediately, no done; next start with 7*6 -> 16'h002A.
